// File: rtl/axis_pattern_gen_if.sv
// AXI4-Stream video bus carrying one pixel per beat, TUSER = start of frame, TLAST = end of line.

interface axis_pattern_gen_if #(
    parameter int unsigned DATA_W = 24
);
    logic [DATA_W-1:0] TDATA;
    logic              TLAST;
    logic              TUSER;
    logic              TVALID;
    logic              TREADY;

    modport master (output TDATA, output TLAST, output TUSER, output TVALID, input TREADY);
    modport slave  (input TDATA, input TLAST, input TUSER, input TVALID, output TREADY);
endinterface

// File: rtl/axis_pattern_gen.sv
// Video test-pattern source: a paced raster walker fills a FWFT FIFO that feeds the AXIS master.
// Raster stalls (never drops) when the FIFO is full; STOP or the frame limit ends at a frame boundary.

module axis_pattern_gen #(
    parameter int unsigned H_ACTIVE   = 800,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned H_TOTAL    = 1056,
    parameter int unsigned V_TOTAL    = 525,
    parameter int unsigned COMP_W     = 8,
    parameter int unsigned FIFO_DEPTH = 1024,
    parameter int unsigned PACE       = 3
) (
    input  logic                      AXIS_VID_ACLK,
    input  logic                      AXIS_VID_ARESETN,
    axis_pattern_gen_if.master        AXIS_VID,
    input  logic [1:0]                MODE,
    input  logic [15:0]               NFRAMES,
    input  logic                      GO,
    input  logic                      STOP,
    output logic                      RUN,
    output logic [15:0]               FRAME_CNT
);
    localparam int unsigned DW = 3 * COMP_W;
    localparam int unsigned EW = DW + 2;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned XW = $clog2(H_TOTAL);
    localparam int unsigned YW = $clog2(V_TOTAL);

    typedef enum logic [1:0] {StIdle, StGen, StDrain} state_e;

    state_e            r_state, w_state_d;
    logic [XW-1:0]     r_x;
    logic [YW-1:0]     r_y;
    logic [3:0]        r_pace;
    logic [15:0]       r_frame_cnt;
    logic [15:0]       r_nframes;
    logic [1:0]        r_mode;
    logic              r_stop_req;
    logic [AW:0]       r_wr_ptr, r_rd_ptr;
    logic [EW-1:0]     r_mem [FIFO_DEPTH];

    logic              w_start, w_step, w_frame_end, w_limit, w_wr, w_pop, w_empty, w_full;
    logic              w_x_last, w_y_last, w_active, w_chk;
    logic [COMP_W-1:0] w_cy, w_r, w_g, w_b;
    logic [8:0]        w_cx;
    logic [EW-1:0]     w_entry, w_head;

    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop    = !w_empty && AXIS_VID.TREADY;
    assign w_head   = r_mem[r_rd_ptr[AW-1:0]];

    assign w_x_last    = (r_x == XW'(H_TOTAL - 1));
    assign w_y_last    = (r_y == YW'(V_TOTAL - 1));
    assign w_frame_end = w_x_last && w_y_last;
    assign w_active    = (32'(r_x) < H_ACTIVE) && (32'(r_y) < V_ACTIVE);
    assign w_limit     = (r_nframes != 16'd0) && ((r_frame_cnt + 16'd1) == r_nframes);
    assign w_start     = (r_state == StIdle) && GO;
    assign w_wr        = w_step && w_active;

    always_comb begin
        w_state_d = r_state;
        w_step    = 1'b0;
        unique case (r_state)
            StIdle: if (GO) w_state_d = StGen;
            StGen: begin
                w_step = (r_pace == 4'd0) && !w_full;
                // STOP arriving on the frame-end clock still ends this frame
                if (w_step && w_frame_end && (r_stop_req || STOP || w_limit)) w_state_d = StDrain;
            end
            StDrain: if (w_empty) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge AXIS_VID_ACLK or negedge AXIS_VID_ARESETN) begin
        if (!AXIS_VID_ARESETN) r_state <= StIdle;
        else                   r_state <= w_state_d;
    end

    always_ff @(posedge AXIS_VID_ACLK or negedge AXIS_VID_ARESETN) begin
        if (!AXIS_VID_ARESETN) begin
            r_x         <= '0;
            r_y         <= '0;
            r_pace      <= '0;
            r_frame_cnt <= '0;
            r_nframes   <= '0;
            r_mode      <= '0;
            r_stop_req  <= 1'b0;
        end else if (w_start) begin
            r_x         <= '0;
            r_y         <= '0;
            r_pace      <= '0;
            r_frame_cnt <= '0;
            r_nframes   <= NFRAMES;
            r_mode      <= MODE;
            r_stop_req  <= 1'b0;
        end else begin
            if (r_state == StGen && STOP) r_stop_req <= 1'b1;
            if (w_step) begin
                r_pace <= 4'(PACE - 1);
                if (w_x_last) begin
                    r_x <= '0;
                    r_y <= w_y_last ? '0 : r_y + YW'(1);
                end else begin
                    r_x <= r_x + XW'(1);
                end
                if (w_frame_end) r_frame_cnt <= r_frame_cnt + 16'd1;
            end else if (r_pace != 4'd0) begin
                r_pace <= r_pace - 4'd1;
            end
        end
    end

    always_comb begin
        w_cy  = COMP_W'(r_frame_cnt >> 1) + COMP_W'(r_y);
        w_cx  = 9'(r_frame_cnt) + 9'(r_x);
        w_chk = 1'((32'(r_x) >> 5) ^ (32'(r_y) >> 5) ^ 32'(r_frame_cnt));
        w_r   = '0;
        w_g   = '0;
        w_b   = '0;
        unique case (r_mode)
            2'd0: begin
                w_r = w_cx[8] ? w_cy : '0;
                w_g = w_cx[7] ? w_cy : '0;
                w_b = w_cx[6] ? w_cy : '0;
            end
            2'd1: begin
                w_r = COMP_W'(r_x);
                w_g = COMP_W'(r_x);
                w_b = COMP_W'(r_x);
            end
            2'd2: {w_r, w_g, w_b} = {DW{w_chk}};
            default: begin
                w_r = COMP_W'(r_frame_cnt);
                w_g = COMP_W'(r_frame_cnt);
                w_b = COMP_W'(r_frame_cnt);
            end
        endcase
        w_entry = {(r_x == '0) && (r_y == '0), (32'(r_x) == H_ACTIVE - 1), w_r, w_b, w_g};
    end

    always_ff @(posedge AXIS_VID_ACLK or negedge AXIS_VID_ARESETN) begin
        if (!AXIS_VID_ARESETN) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (w_start) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + (AW + 1)'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + (AW + 1)'(1);
        end
    end

    // Storage is not reset; stale entries are masked by the empty flag on the output side.
    always_ff @(posedge AXIS_VID_ACLK) begin
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= w_entry;
    end

    assign AXIS_VID.TVALID = !w_empty;
    assign AXIS_VID.TDATA  = w_empty ? '0 : w_head[DW-1:0];
    assign AXIS_VID.TLAST  = w_empty ? 1'b0 : w_head[DW];
    assign AXIS_VID.TUSER  = w_empty ? 1'b0 : w_head[DW+1];
    assign RUN             = (r_state != StIdle);
    assign FRAME_CNT       = r_frame_cnt;
endmodule
